// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit: FSM states, funct3 codes,
// data width and timeout default, plus the alignment check used by the trap option.
package mem_access_unit_pkg;

    localparam int CPU_DATA_BITS = 32;
    localparam int MAX_WAIT_DEF  = 255;

    localparam logic [2:0] FNC_LB  = 3'b000;
    localparam logic [2:0] FNC_LH  = 3'b001;
    localparam logic [2:0] FNC_LW  = 3'b010;
    localparam logic [2:0] FNC_LBU = 3'b100;
    localparam logic [2:0] FNC_LHU = 3'b101;
    localparam logic [2:0] FNC_SB  = 3'b000;
    localparam logic [2:0] FNC_SH  = 3'b001;
    localparam logic [2:0] FNC_SW  = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } mau_state_t;

    // Store funct3 codes alias the load ones, so LH covers SH and LW covers SW.
    function automatic logic is_misaligned(input logic [2:0] funct, input logic [1:0] lo);
        case (funct)
            FNC_LH, FNC_LHU: return lo[0];
            FNC_LW:          return (lo != 2'b00);
            default:         return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_store_align.sv
// Store lane steering: byte write enables from funct3/addr[1:0] and
// lane-replicated store data so any byte/half lands on every possible lane.
module mem_access_unit_store_align
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_BITS
) (
    input  logic [2:0]        i_funct,
    input  logic [1:0]        i_addr_lo,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [3:0]        o_we,
    output logic [DATA_W-1:0] o_wdata
);

    always_comb begin
        o_we    = 4'b0000;
        o_wdata = i_wdata;
        case (i_funct)
            FNC_SB: begin
                o_we    = 4'b0001 << i_addr_lo;
                o_wdata = {(DATA_W/8){i_wdata[7:0]}};
            end
            FNC_SH: begin
                o_we    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {(DATA_W/16){i_wdata[15:0]}};
            end
            FNC_SW: begin
                o_we    = 4'b1111;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: req/gnt/rvalid handshake, pipeline stall, timeout
// abort, raw word to WB. Optional misalignment trap under `MISALIGN_TRAP_EN.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W   = CPU_DATA_BITS,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic              ex_is_load,
    input  logic              ex_is_store,
    input  logic [2:0]        ex_funct,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    output logic              stall,
    output logic              dmem_req,
    output logic [3:0]        dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic              dmem_gnt,
    input  logic              dmem_rvalid,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              wb_valid,
    output logic [2:0]        wb_funct,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_rdata,
    output logic              wb_timeout,
    output logic              wb_misalign
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    mau_state_t        r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_funct;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_is_store;
    logic              r_timeout;
    logic              r_misalign;

    logic              w_accept;
    logic              w_misalign;
    logic              w_to;
    logic              w_busy;
    logic              w_stall;
    logic              w_req;
    logic              w_cap;
    logic              w_resp;
    logic [3:0]        w_we;
    logic [DATA_W-1:0] w_wdata;

    assign w_accept = ex_valid & (ex_is_load | ex_is_store);
    assign w_busy   = (r_state == S_REQ) | (r_state == S_WAIT);
    // Timeout cycle drops the request, so a gnt/rvalid in it is simply not looked at.
    assign w_to     = w_busy & (r_cnt == CNT_W'(MAX_WAIT));
    assign w_resp   = (r_state == S_RESP);

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = is_misaligned(ex_funct, ex_addr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        w_req   = 1'b0;
        w_cap   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_stall = 1'b1;
                    w_next  = w_misalign ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                w_stall = 1'b1;
                if (w_to) begin
                    w_next = S_RESP;
                end else begin
                    w_req = 1'b1;
                    if (dmem_gnt) begin
                        if (r_is_store) begin
                            w_next = S_RESP;
                        end else if (dmem_rvalid) begin
                            w_cap  = 1'b1;
                            w_next = S_RESP;
                        end else begin
                            w_next = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                w_stall = 1'b1;
                if (w_to) begin
                    w_next = S_RESP;
                end else if (dmem_rvalid) begin
                    w_cap  = 1'b1;
                    w_next = S_RESP;
                end
            end
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_funct    <= '0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_is_store <= 1'b0;
            r_timeout  <= 1'b0;
            r_misalign <= 1'b0;
        end else if ((r_state == S_IDLE) && w_accept) begin
            r_cnt      <= '0;
            r_funct    <= ex_funct;
            r_addr     <= ex_addr;
            r_wdata    <= ex_wdata;
            r_rdata    <= '0;
            r_is_store <= ex_is_store & ~ex_is_load;
            r_timeout  <= 1'b0;
            r_misalign <= w_misalign;
        end else begin
            if (w_busy) r_cnt     <= r_cnt + CNT_W'(1);
            if (w_cap)  r_rdata   <= dmem_rdata;
            if (w_to)   r_timeout <= 1'b1;
        end
    end

    mem_access_unit_store_align #(
        .DATA_W (DATA_W)
    ) u_store_align (
        .i_funct   (r_funct),
        .i_addr_lo (r_addr[1:0]),
        .i_wdata   (r_wdata),
        .o_we      (w_we),
        .o_wdata   (w_wdata)
    );

    assign stall       = w_stall;
    assign dmem_req    = w_req;
    assign dmem_addr   = {r_addr[ADDR_W-1:2], 2'b00};
    assign dmem_we     = (w_req & r_is_store) ? w_we : 4'b0000;
    assign dmem_wdata  = w_wdata;

    assign wb_valid    = w_resp;
    assign wb_funct    = w_resp ? r_funct    : 3'b000;
    assign wb_addr     = w_resp ? r_addr     : '0;
    assign wb_rdata    = w_resp ? r_rdata    : '0;
    assign wb_timeout  = w_resp & r_timeout;
    assign wb_misalign = w_resp & r_misalign;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (MAX_WAIT=4): expected WB records are
// queued at issue and checked by a negedge monitor on each wb_valid.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk, rst;
    logic        ex_valid, ex_is_load, ex_is_store;
    logic [2:0]  ex_funct;
    logic [31:0] ex_addr, ex_wdata;
    logic        stall, dmem_req;
    logic [3:0]  dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [2:0]  wb_funct;
    logic [31:0] wb_addr, wb_rdata;
    logic        wb_timeout, wb_misalign;

    typedef struct {
        logic [2:0]  funct;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        to;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ex_is_load  (ex_is_load),
        .ex_is_store (ex_is_store),
        .ex_funct    (ex_funct),
        .ex_addr     (ex_addr),
        .ex_wdata    (ex_wdata),
        .stall       (stall),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .dmem_addr   (dmem_addr),
        .dmem_wdata  (dmem_wdata),
        .dmem_gnt    (dmem_gnt),
        .dmem_rvalid (dmem_rvalid),
        .dmem_rdata  (dmem_rdata),
        .wb_valid    (wb_valid),
        .wb_funct    (wb_funct),
        .wb_addr     (wb_addr),
        .wb_rdata    (wb_rdata),
        .wb_timeout  (wb_timeout),
        .wb_misalign (wb_misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ld, input logic st, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d);
        ex_valid    = 1'b1;
        ex_is_load  = ld;
        ex_is_store = st;
        ex_funct    = f;
        ex_addr     = a;
        ex_wdata    = d;
    endtask

    task automatic push(input logic [2:0] f, input logic [31:0] a, input logic [31:0] r,
                        input logic to, input logic mis);
        exp_t e;
        e.funct = f; e.addr = a; e.rdata = r; e.to = to; e.mis = mis;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            if (sb.size() == 0) begin
                chk("wb_unexpected", 32'(wb_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_funct",    32'(wb_funct),    32'(e.funct));
                chk("wb_addr",     wb_addr,          e.addr);
                chk("wb_rdata",    wb_rdata,         e.rdata);
                chk("wb_timeout",  32'(wb_timeout),  32'(e.to));
                chk("wb_misalign", 32'(wb_misalign), 32'(e.mis));
            end
        end
    end

    initial begin
        rst = 1'b1; ex_valid = 0; ex_is_load = 0; ex_is_store = 0;
        ex_funct = 0; ex_addr = 0; ex_wdata = 0;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
        step(); step();
        chk("rst_stall", 32'(stall), 0);
        chk("rst_req", 32'(dmem_req), 0);
        chk("rst_we", 32'(dmem_we), 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_wb_rdata", wb_rdata, 0);
        rst = 1'b0;
        step();

        // SB to the top byte lane, granted in the first REQ cycle
        drive(0, 1, FNC_SB, 32'h1003, 32'h0000_00A5); #1;
        chk("sb_stall_accept", 32'(stall), 1);
        push(FNC_SB, 32'h1003, 0, 0, 0);
        step(); ex_valid = 0; dmem_gnt = 1; #1;
        chk("sb_req", 32'(dmem_req), 1);
        chk("sb_addr", dmem_addr, 32'h1000);
        chk("sb_we", 32'(dmem_we), 32'b1000);
        chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
        chk("sb_stall_req", 32'(stall), 1);
        step(); dmem_gnt = 0; #1;
        chk("sb_resp_stall", 32'(stall), 0);
        chk("sb_resp_valid", 32'(wb_valid), 1);
        step();
        chk("sb_pulse_end", 32'(wb_valid), 0);

        // LW: early rvalid ignored, gnt on 2nd REQ cycle, data 2 cycles later
        drive(1, 0, FNC_LW, 32'h2000, 0); #1;
        push(FNC_LW, 32'h2000, 32'hDEAD_BEEF, 0, 0);
        step(); ex_valid = 0; dmem_rvalid = 1; dmem_rdata = 32'hBAD0_BAD0; #1;
        chk("lw_req1", 32'(dmem_req), 1);
        chk("lw_we", 32'(dmem_we), 0);
        step(); dmem_rvalid = 0; dmem_gnt = 1; #1;
        chk("lw_req2", 32'(dmem_req), 1);
        step(); dmem_gnt = 0; #1;
        chk("lw_wait_req", 32'(dmem_req), 0);
        chk("lw_wait_stall", 32'(stall), 1);
        step(); dmem_rvalid = 1; dmem_rdata = 32'hDEAD_BEEF; #1;
        chk("lw_wait2_stall", 32'(stall), 1);
        step(); dmem_rvalid = 0; #1;
        chk("lw_resp_valid", 32'(wb_valid), 1);
        step();
        chk("lw_pulse_end", 32'(wb_valid), 0);

        // LBU with gnt and rvalid together
        drive(1, 0, FNC_LBU, 32'h3002, 0); #1;
        push(FNC_LBU, 32'h3002, 32'h1122_3344, 0, 0);
        step(); ex_valid = 0; dmem_gnt = 1; dmem_rvalid = 1; dmem_rdata = 32'h1122_3344; #1;
        chk("lbu_req", 32'(dmem_req), 1);
        step(); dmem_gnt = 0; dmem_rvalid = 0; #1;
        chk("lbu_resp_valid", 32'(wb_valid), 1);
        chk("lbu_lane", 32'(wb_addr[1:0]), 32'd2);
        step();

        // timeout: 4 REQ cycles, then abort; a late gnt/rvalid is ignored
        drive(1, 0, FNC_LW, 32'h5000, 0); #1;
        push(FNC_LW, 32'h5000, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(); ex_valid = 0; #1;
            chk("to_req_held", 32'(dmem_req), 1);
        end
        step(); dmem_gnt = 1; dmem_rvalid = 1; dmem_rdata = 32'hFFFF_FFFF; #1;
        chk("to_req_drop", 32'(dmem_req), 0);
        chk("to_stall", 32'(stall), 1);
        step(); dmem_gnt = 0; dmem_rvalid = 0; #1;
        chk("to_resp_valid", 32'(wb_valid), 1);
        chk("to_flag", 32'(wb_timeout), 1);
        step();

        // SW after the timeout proceeds normally
        drive(0, 1, FNC_SW, 32'h6000, 32'h1234_5678); #1;
        push(FNC_SW, 32'h6000, 0, 0, 0);
        step(); ex_valid = 0; dmem_gnt = 1; #1;
        chk("sw_req", 32'(dmem_req), 1);
        chk("sw_we", 32'(dmem_we), 32'b1111);
        chk("sw_wdata", dmem_wdata, 32'h1234_5678);
        step(); dmem_gnt = 0; #1;
        chk("sw_resp_valid", 32'(wb_valid), 1);
        step();

        // SH to the upper half
        drive(0, 1, FNC_SH, 32'h0000_0006, 32'h0000_BEEF); #1;
        push(FNC_SH, 32'h0000_0006, 0, 0, 0);
        step(); ex_valid = 0; dmem_gnt = 1; #1;
        chk("sh_addr", dmem_addr, 32'h4);
        chk("sh_we", 32'(dmem_we), 32'b1100);
        chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        step(); dmem_gnt = 0; #1;
        step();

        // reset while in WAIT; rvalid after reset must not complete anything
        drive(1, 0, FNC_LW, 32'h7000, 0); #1;
        step(); ex_valid = 0; dmem_gnt = 1; #1;
        step(); dmem_gnt = 0; #1;
        chk("rw_wait_stall", 32'(stall), 1);
        rst = 1;
        step(); rst = 0; dmem_rvalid = 1; dmem_rdata = 32'hCAFE_F00D; #1;
        chk("rw_stall", 32'(stall), 0);
        chk("rw_req", 32'(dmem_req), 0);
        step(); dmem_rvalid = 0; #1;
        chk("rw_no_wb", 32'(wb_valid), 0);
        step();
        chk("rw_no_wb2", 32'(wb_valid), 0);

        // misaligned SW
`ifdef MISALIGN_TRAP_EN
        drive(0, 1, FNC_SW, 32'h4002, 32'h55AA_55AA); #1;
        push(FNC_SW, 32'h4002, 0, 0, 1);
        chk("mis_stall", 32'(stall), 1);
        step(); ex_valid = 0; #1;
        chk("mis_req", 32'(dmem_req), 0);
        chk("mis_we", 32'(dmem_we), 0);
        chk("mis_valid", 32'(wb_valid), 1);
        chk("mis_flag", 32'(wb_misalign), 1);
        step();
`else
        drive(0, 1, FNC_SW, 32'h4002, 32'h55AA_55AA); #1;
        push(FNC_SW, 32'h4002, 0, 0, 0);
        step(); ex_valid = 0; dmem_gnt = 1; #1;
        chk("mis_req", 32'(dmem_req), 1);
        chk("mis_addr", dmem_addr, 32'h4000);
        chk("mis_we", 32'(dmem_we), 32'b1111);
        step(); dmem_gnt = 0; #1;
        chk("mis_valid", 32'(wb_valid), 1);
        step();
`endif

        // non-memory op is not accepted
        drive(0, 0, FNC_LW, 32'h9000, 0); #1;
        chk("nop_stall", 32'(stall), 0);
        step(); ex_valid = 0; #1;
        chk("nop_req", 32'(dmem_req), 0);

        // both kind flags set: handled as a load
        drive(1, 1, FNC_LW, 32'h8000, 32'hFFFF_FFFF); #1;
        push(FNC_LW, 32'h8000, 32'h0BAD_F00D, 0, 0);
        step(); ex_valid = 0; dmem_gnt = 1; dmem_rvalid = 1; dmem_rdata = 32'h0BAD_F00D; #1;
        chk("both_we", 32'(dmem_we), 0);
        step(); dmem_gnt = 0; dmem_rvalid = 0; #1;
        chk("both_valid", 32'(wb_valid), 1);
        step(); step();

        chk("sb_drained", 32'(sb.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
